cipher_cfg_loader: RTL

//  Upstream config stage for the dual XOR stream cipher: captures an M-bit key/seed word in parallel,

---
 rtl/cipher_cfg_loader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cipher_cfg_loader.sv
// cipher_cfg_loader: captures an M-bit key/seed word on a start strobe and
// shifts it MSB-first into the cipher's serial config chain. With
// CFG_READBACK_EN defined, a second pass re-shifts the key and compares the
// chain tail to it; the chain is left holding the key either way.
//
// Optional feature macro: CFG_READBACK_EN (undefined: no readback pass,
// i_cfg_i unused, o_verify_ok/o_err tied 0).
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_start      load request, sampled only in IDLE
//   i_key[M]     key/seed word, captured on the accepted start edge
//   o_busy       high from the cycle after start until DONE is left
//   o_done       one-cycle pulse at sequence completion
//   o_verify_ok  last readback matched; held until next accepted start
//   o_err        last readback mismatched; held until next accepted start
//   o_cfg_en     cipher chain shift enable
//   o_cfg_o      serial key bit to cipher cfg_i, MSB first, 0 when idle
//   i_cfg_i      chain tail from cipher cfg_o
module cipher_cfg_loader #(
    parameter int unsigned M = 36
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [M-1:0] i_key,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_verify_ok,
    output logic         o_err,
    output logic         o_cfg_en,
    output logic         o_cfg_o,
    input  logic         i_cfg_i
);

    localparam int unsigned CNT_W = $clog2(M);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [M-1:0]     r_shadow, w_shadow_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_cfg_en, w_cfg_en_nxt;
    logic             r_cfg_o, w_cfg_o_nxt;
`ifdef CFG_READBACK_EN
    logic             r_miss, w_miss_nxt;
    logic             r_verify_ok, w_verify_ok_nxt;
    logic             r_err, w_err_nxt;
`else
    logic             w_unused_cfg_i;
    assign w_unused_cfg_i = i_cfg_i;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_en    <= 1'b0;
            r_cfg_o     <= 1'b0;
`ifdef CFG_READBACK_EN
            r_miss      <= 1'b0;
            r_verify_ok <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cfg_en    <= w_cfg_en_nxt;
            r_cfg_o     <= w_cfg_o_nxt;
`ifdef CFG_READBACK_EN
            r_miss      <= w_miss_nxt;
            r_verify_ok <= w_verify_ok_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so they are
    // valid in the same cycle the state is entered.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shadow_nxt    = r_shadow;
`ifdef CFG_READBACK_EN
        w_miss_nxt      = r_miss;
        w_verify_ok_nxt = r_verify_ok;
        w_err_nxt       = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_shadow_nxt    = i_key;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_SHIFT;
`ifdef CFG_READBACK_EN
                    w_miss_nxt      = 1'b0;
                    w_verify_ok_nxt = 1'b0;
                    w_err_nxt       = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                // Rotate so the shadow returns to the key after M shifts.
                w_shadow_nxt = {r_shadow[M-2:0], r_shadow[M-1]};
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
`ifdef CFG_READBACK_EN
                    w_state_nxt = S_VERIFY;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_VERIFY: begin
`ifdef CFG_READBACK_EN
                // Re-shifting the key keeps the chain intact while its tail
                // walks past in step with shadow[M-1].
                w_shadow_nxt = {r_shadow[M-2:0], r_shadow[M-1]};
                w_miss_nxt   = r_miss | (i_cfg_i ^ r_shadow[M-1]);
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt       = '0;
                    w_verify_ok_nxt = ~w_miss_nxt;
                    w_err_nxt       = w_miss_nxt;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cfg_en_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_VERIFY);
        w_cfg_o_nxt  = w_cfg_en_nxt & w_shadow_nxt[M-1];
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE);
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_cfg_en = r_cfg_en;
    assign o_cfg_o  = r_cfg_o;
`ifdef CFG_READBACK_EN
    assign o_verify_ok = r_verify_ok;
    assign o_err       = r_err;
`else
    assign o_verify_ok = 1'b0;
    assign o_err       = 1'b0;
`endif

endmodule
